// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB through the TLB ports and returns CSR updates.
// Optional macro TLBFILL_LFSR_EN selects an LFSR-based TLBFILL index instead of the wrapping counter.
`default_nettype none

module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IDXW = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vppn,
    input  logic [9:0]      csr_asid,
    input  logic [18:0]     csr_ehi_vppn,
    input  logic [IDXW-1:0] csr_idx,
    input  logic [5:0]      csr_ps,
    input  logic            csr_ne,
    input  logic [31:0]     csr_elo0,
    input  logic [31:0]     csr_elo1,
    input  logic [5:0]      csr_ecode,
    output logic [18:0]     s0_vppn,
    output logic [9:0]      s0_asid,
    input  logic            s0_hit,
    input  logic [IDXW-1:0] s0_index,
    output logic [IDXW-1:0] r_index,
    input  logic            r_ne,
    input  logic [18:0]     r_vppn,
    input  logic [9:0]      r_asid,
    input  logic            r_g,
    input  logic [5:0]      r_ps,
    input  logic [31:0]     r_elo0,
    input  logic [31:0]     r_elo1,
    output logic            w_en,
    output logic [IDXW-1:0] w_index,
    output logic [18:0]     w_vppn,
    output logic [9:0]      w_asid,
    output logic            w_g,
    output logic [5:0]      w_ps,
    output logic            w_ne,
    output logic [31:0]     w_elo0,
    output logic [31:0]     w_elo1,
    output logic            f_en,
    output logic [4:0]      f_op,
    output logic [9:0]      f_asid,
    output logic [18:0]     f_vppn,
    output logic            upd_valid,
    output logic            upd_idx_we,
    output logic            upd_ehi_we,
    output logic            upd_elo_we,
    output logic            upd_asid_we,
    output logic [IDXW-1:0] upd_idx,
    output logic            upd_ne,
    output logic [5:0]      upd_ps,
    output logic [18:0]     upd_vppn,
    output logic [31:0]     upd_elo0,
    output logic [31:0]     upd_elo1,
    output logic [9:0]      upd_asid,
    output logic            done,
    output logic            ine_exc
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RESP   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t          state_q, state_d;
    logic [IDXW-1:0] fill_idx;
    logic            accept;

    logic [2:0]      op_q;
    logic [4:0]      inv_op_q;
    logic [9:0]      inv_asid_q;
    logic [18:0]     inv_vppn_q;
    logic [9:0]      asid_q;
    logic [18:0]     vppn_q;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] fill_q;
    logic [5:0]      ps_q;
    logic            ne_q;
    logic [31:0]     elo0_q;
    logic [31:0]     elo1_q;
    logic [5:0]      ecode_q;

    logic            hit_q;
    logic [IDXW-1:0] sidx_q;
    logic            rne_q;
    logic [18:0]     rvppn_q;
    logic [9:0]      rasid_q;
    logic [5:0]      rps_q;
    logic [31:0]     relo0_q;
    logic [31:0]     relo1_q;

    logic            inv_bad;

    assign accept  = op_valid && (state_q == ST_IDLE);
    assign inv_bad = (inv_op_q > 5'd6);

`ifdef TLBFILL_LFSR_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'h01;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign fill_idx = lfsr_q[IDXW-1:0];
`else
    logic [IDXW-1:0] fill_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) fill_cnt_q <= '0;
        else       fill_cnt_q <= fill_cnt_q + IDXW'(1);
    end
    assign fill_idx = fill_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            asid_q     <= '0;
            vppn_q     <= '0;
            idx_q      <= '0;
            fill_q     <= '0;
            ps_q       <= '0;
            ne_q       <= 1'b0;
            elo0_q     <= '0;
            elo1_q     <= '0;
            ecode_q    <= '0;
            hit_q      <= 1'b0;
            sidx_q     <= '0;
            rne_q      <= 1'b0;
            rvppn_q    <= '0;
            rasid_q    <= '0;
            rps_q      <= '0;
            relo0_q    <= '0;
            relo1_q    <= '0;
        end else begin
            if (accept) begin
                op_q       <= op_code;
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vppn_q <= inv_vppn;
                asid_q     <= csr_asid;
                vppn_q     <= csr_ehi_vppn;
                idx_q      <= csr_idx;
                fill_q     <= fill_idx;
                ps_q       <= csr_ps;
                ne_q       <= csr_ne;
                elo0_q     <= csr_elo0;
                elo1_q     <= csr_elo1;
                ecode_q    <= csr_ecode;
            end
            if (state_q == ST_RESP) begin
                hit_q   <= s0_hit;
                sidx_q  <= s0_index;
                rne_q   <= r_ne;
                rvppn_q <= r_vppn;
                rasid_q <= r_asid;
                rps_q   <= r_ps;
                // The entry's single G bit is reflected into both ELO G fields
                relo0_q <= (r_elo0 & ~32'h40) | (32'(r_g) << 6);
                relo1_q <= (r_elo1 & ~32'h40) | (32'(r_g) << 6);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_ready    = 1'b0;
        s0_vppn     = '0;
        s0_asid     = '0;
        r_index     = '0;
        w_en        = 1'b0;
        w_index     = '0;
        w_vppn      = '0;
        w_asid      = '0;
        w_g         = 1'b0;
        w_ps        = '0;
        w_ne        = 1'b0;
        w_elo0      = '0;
        w_elo1      = '0;
        f_en        = 1'b0;
        f_op        = '0;
        f_asid      = '0;
        f_vppn      = '0;
        upd_valid   = 1'b0;
        upd_idx_we  = 1'b0;
        upd_ehi_we  = 1'b0;
        upd_elo_we  = 1'b0;
        upd_asid_we = 1'b0;
        upd_idx     = '0;
        upd_ne      = 1'b0;
        upd_ps      = '0;
        upd_vppn    = '0;
        upd_elo0    = '0;
        upd_elo1    = '0;
        upd_asid    = '0;
        done        = 1'b0;
        ine_exc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_d = ST_REQ;
            end
            ST_REQ, ST_RESP: begin
                if (op_q == OP_SRCH) begin
                    s0_vppn = vppn_q;
                    s0_asid = asid_q;
                end
                if (op_q == OP_RD) r_index = idx_q;
                if (state_q == ST_REQ) begin
                    if (op_q == OP_WR || op_q == OP_FILL) begin
                        w_en    = 1'b1;
                        w_index = (op_q == OP_FILL) ? fill_q : idx_q;
                        w_vppn  = vppn_q;
                        w_asid  = asid_q;
                        w_g     = elo0_q[6] & elo1_q[6];
                        w_ps    = ps_q;
                        // A refill exception always writes a valid entry
                        w_ne    = (ecode_q == 6'h3F) ? 1'b0 : ne_q;
                        w_elo0  = elo0_q;
                        w_elo1  = elo1_q;
                    end
                    if (op_q == OP_INV && !inv_bad) begin
                        f_en   = 1'b1;
                        f_op   = inv_op_q;
                        f_asid = inv_asid_q;
                        f_vppn = inv_vppn_q;
                    end
                    state_d = (op_q == OP_SRCH || op_q == OP_RD) ? ST_RESP : ST_COMMIT;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                done    = 1'b1;
                state_d = ST_IDLE;
                if (op_q == OP_SRCH) begin
                    upd_valid  = 1'b1;
                    upd_idx_we = 1'b1;
                    upd_idx    = hit_q ? sidx_q : idx_q;
                    upd_ne     = ~hit_q;
                end
                if (op_q == OP_RD) begin
                    upd_valid   = 1'b1;
                    upd_idx_we  = 1'b1;
                    upd_ehi_we  = 1'b1;
                    upd_elo_we  = 1'b1;
                    upd_asid_we = 1'b1;
                    upd_idx     = idx_q;
                    upd_ne      = rne_q;
                    if (!rne_q) begin
                        upd_ps   = rps_q;
                        upd_vppn = rvppn_q;
                        upd_elo0 = relo0_q;
                        upd_elo1 = relo1_q;
                        upd_asid = rasid_q;
                    end
                end
                if (op_q == OP_INV) ine_exc = inv_bad;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire
